// File: rtl/instr_fetch_if.sv
// instr_fetch_if: load port, fetch controls and fetched-instruction outputs of the fetch stage
interface instr_fetch_if #(
    parameter int ADDR_W = 8
);
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;
    logic              start;
    logic              stall;
    logic              branch_taken;
    logic [31:0]       branch_target;
    logic [31:0]       instruction;
    logic [5:0]        opcode;
    logic [31:0]       pc_out;
    logic              valid;
    logic              halted;
    logic [31:0]       fetch_count;

    modport master (
        output load_en, load_addr, load_data, start, stall, branch_taken, branch_target,
        input  instruction, opcode, pc_out, valid, halted, fetch_count
    );

    modport slave (
        input  load_en, load_addr, load_data, start, stall, branch_taken, branch_target,
        output instruction, opcode, pc_out, valid, halted, fetch_count
    );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: PC, word-addressed instruction memory and registered fetch with stall, branch and halt
module instr_fetch #(
    parameter int          IMEM_DEPTH = 256,
    parameter int          ADDR_W     = 8,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input logic         clk,
    input logic         reset,
    instr_fetch_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    logic [31:0] mem [IMEM_DEPTH];

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic [31:0] count_q, count_d;
    logic [31:0] fetch_word;

    assign fetch_word = mem[pc_q[ADDR_W+1:2]];

    // Program loads are accepted whenever the stage is not executing.
    always_ff @(posedge clk) begin
        if (bus.load_en && state_q != RUN) mem[bus.load_addr] <= bus.load_data;
    end

    // Next-state: start from IDLE/HALT, otherwise branch > halt > sequential fetch unless stalled.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        count_d  = count_q;
        if (state_q != RUN) begin
            if (bus.start) begin
                state_d  = RUN;
                pc_d     = RESET_PC;
                count_d  = '0;
                halted_d = 1'b0;
                valid_d  = 1'b0;
                instr_d  = '0;
            end
        end else if (!bus.stall) begin
            if (bus.branch_taken) begin
                pc_d    = bus.branch_target & ~32'd3;
                instr_d = '0;
                valid_d = 1'b0;
            end else if (fetch_word == HALT_WORD) begin
                state_d  = HALT;
                instr_d  = '0;
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end else begin
                instr_d  = fetch_word;
                pc_out_d = pc_q;
                pc_d     = pc_q + 32'd4;
                valid_d  = 1'b1;
                count_d  = count_q + 32'd1;
            end
        end
    end

    // All stage registers, with reset taking precedence over every other condition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    assign bus.instruction = instr_q;
    assign bus.opcode      = instr_q[31:26];
    assign bus.pc_out      = pc_out_q;
    assign bus.valid       = valid_q;
    assign bus.halted      = halted_q;
    assign bus.fetch_count = count_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed test-plan scenarios plus random traffic against a behavioural fetch model
module tb_instr_fetch;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_fetch_if #(.ADDR_W(8)) bus ();

    instr_fetch #(
        .IMEM_DEPTH(256),
        .ADDR_W(8),
        .RESET_PC(32'h0),
        .HALT_WORD(HALT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: program memory plus what the decoder should currently see.
    logic [31:0] m_mem [256];
    bit          m_running;
    bit          m_halted;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc_out;
    bit          m_valid;
    logic [31:0] m_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        logic [31:0] word;
        if (reset) begin
            m_running = 0; m_halted = 0; m_pc = 0; m_instr = 0;
            m_pc_out = 0; m_valid = 0; m_count = 0;
        end else if (!m_running) begin
            if (bus.load_en) m_mem[bus.load_addr] = bus.load_data;
            if (bus.start) begin
                m_running = 1; m_halted = 0; m_pc = 0; m_count = 0;
                m_valid = 0; m_instr = 0;
            end
        end else if (!bus.stall) begin
            word = m_mem[(m_pc / 4) % 256];
            if (bus.branch_taken) begin
                m_pc = (bus.branch_target / 4) * 4;
                m_instr = 0; m_valid = 0;
            end else if (word == HALT) begin
                m_running = 0; m_halted = 1; m_instr = 0; m_valid = 0;
            end else begin
                m_instr = word; m_pc_out = m_pc; m_pc = m_pc + 4;
                m_valid = 1; m_count = m_count + 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("instruction", bus.instruction, m_instr);
        check("opcode", {26'b0, bus.opcode}, {26'b0, m_instr[31:26]});
        check("pc_out", bus.pc_out, m_pc_out);
        check("valid", {31'b0, bus.valid}, {31'b0, m_valid});
        check("halted", {31'b0, bus.halted}, {31'b0, m_halted});
        check("fetch_count", bus.fetch_count, m_count);
    endtask

    task automatic quiet();
        reset = 0;
        bus.load_en = 0; bus.load_addr = 0; bus.load_data = 0;
        bus.start = 0; bus.stall = 0; bus.branch_taken = 0; bus.branch_target = 0;
    endtask

    task automatic load(input int addr, input logic [31:0] data);
        bus.load_en = 1; bus.load_addr = addr[7:0]; bus.load_data = data;
        tick();
        bus.load_en = 0;
    endtask

    task automatic pulse_start();
        bus.start = 1;
        tick();
        bus.start = 0;
    endtask

    initial begin
        logic [31:0] w;
        quiet();
        reset = 1;
        tick();
        tick();
        reset = 0;
        check("rst_instr", bus.instruction, 32'h0);
        check("rst_opcode", {26'b0, bus.opcode}, 32'h0);
        check("rst_pc_out", bus.pc_out, 32'h0);
        check("rst_valid", {31'b0, bus.valid}, 32'h0);
        check("rst_halted", {31'b0, bus.halted}, 32'h0);
        check("rst_count", bus.fetch_count, 32'h0);

        for (int i = 4; i < 256; i++) begin
            w = $urandom;
            if (w == HALT) w = 32'h1234_5678;
            if (i == 4) w = 32'h8C0B_0004;
            load(i, w);
        end
        load(0, 32'h2008_0001);
        load(1, 32'h0109_4020);
        load(2, 32'h3C0A_1234);
        load(3, HALT);

        // reset and start: three fetches then halt
        pulse_start();
        check("start_no_valid", {31'b0, bus.valid}, 32'h0);
        tick();
        check("f0_instr", bus.instruction, 32'h2008_0001);
        check("f0_opcode", {26'b0, bus.opcode}, 32'h8);
        check("f0_pc_out", bus.pc_out, 32'h0);
        check("f0_valid", {31'b0, bus.valid}, 32'h1);
        tick();
        check("f1_instr", bus.instruction, 32'h0109_4020);
        check("f1_opcode", {26'b0, bus.opcode}, 32'h0);
        check("f1_pc_out", bus.pc_out, 32'h4);
        tick();
        check("f2_instr", bus.instruction, 32'h3C0A_1234);
        check("f2_pc_out", bus.pc_out, 32'h8);
        tick();
        check("halt_halted", {31'b0, bus.halted}, 32'h1);
        check("halt_valid", {31'b0, bus.valid}, 32'h0);
        check("halt_count", bus.fetch_count, 32'h3);
        tick();

        // stall for 3 cycles after the second fetch, with an ignored branch inside
        pulse_start();
        check("restart_halted", {31'b0, bus.halted}, 32'h0);
        tick();
        tick();
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            bus.branch_taken = (i == 1);
            bus.branch_target = 32'h40;
            tick();
            check("stall_pc_out", bus.pc_out, 32'h4);
            check("stall_count", bus.fetch_count, 32'h2);
            check("stall_instr", bus.instruction, 32'h0109_4020);
        end
        quiet();
        tick();
        check("resume_pc_out", bus.pc_out, 32'h8);
        tick();
        tick();

        // branch to unaligned 0x13 while pc=4, then wrap via 0x400
        pulse_start();
        tick();
        bus.branch_taken = 1; bus.branch_target = 32'h13;
        tick();
        check("bubble_valid", {31'b0, bus.valid}, 32'h0);
        check("bubble_instr", bus.instruction, 32'h0);
        check("bubble_count", bus.fetch_count, 32'h1);
        quiet();
        tick();
        check("br_pc_out", bus.pc_out, 32'h10);
        check("br_instr", bus.instruction, 32'h8C0B_0004);
        check("br_count", bus.fetch_count, 32'h2);
        bus.branch_taken = 1; bus.branch_target = 32'h400;
        tick();
        quiet();
        tick();
        check("wrap_pc_out", bus.pc_out, 32'h400);
        check("wrap_instr", bus.instruction, 32'h2008_0001);
        tick();
        tick();
        tick();
        check("wrap_halted", {31'b0, bus.halted}, 32'h1);

        // reset during a stalled branch cycle
        pulse_start();
        tick();
        bus.stall = 1; bus.branch_taken = 1; bus.branch_target = 32'h80; reset = 1;
        tick();
        quiet();
        check("mid_rst_instr", bus.instruction, 32'h0);
        check("mid_rst_valid", {31'b0, bus.valid}, 32'h0);
        check("mid_rst_count", bus.fetch_count, 32'h0);
        check("mid_rst_pc_out", bus.pc_out, 32'h0);
        pulse_start();
        tick();
        check("post_rst_instr", bus.instruction, 32'h2008_0001);
        tick();
        tick();
        tick();

        // restart from HALT with a freshly loaded word 0
        load(0, 32'hAC0C_0008);
        pulse_start();
        tick();
        check("reload_instr", bus.instruction, 32'hAC0C_0008);
        check("reload_pc_out", bus.pc_out, 32'h0);
        check("reload_count", bus.fetch_count, 32'h1);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 127) == 0);
            bus.load_en = ($urandom_range(0, 3) == 0);
            bus.load_addr = 8'($urandom);
            bus.load_data = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
            bus.start = ($urandom_range(0, 7) == 0);
            bus.stall = ($urandom_range(0, 3) == 0);
            bus.branch_taken = ($urandom_range(0, 7) == 0);
            bus.branch_target = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 2047));
            tick();
        end
        quiet();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
